// File: rtl/clock_ctrl.sv
// clock_ctrl: run-control unit for the MIPS board.
// Debounces the mode and step buttons and selects RUN / STEP / BURST.
// It drives a registered single-cycle clock enable to the core and counts
// the cycles in which the core was enabled.
// Optional feature macro: CLOCK_CTRL_BREAK_EN (PC breakpoint halt).

// Per-button synchroniser, debounce filter and press-edge detector.
module clock_ctrl_debounce #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);
    // The counter only ever holds 0 .. DEB_CYCLES-1 before the level flips.
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             stable_d_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise the raw level, filter it and register the rising edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            stable_r   <= 1'b0;
            stable_d_r <= 1'b0;
            press_r    <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            sync1_r    <= btn;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            press_r    <= stable_r & ~stable_d_r;
            if (sync2_r == stable_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                stable_r <= sync2_r;
                cnt_r    <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign press = press_r;
endmodule

module clock_ctrl #(
    parameter int DEB_CYCLES = 250000,
    parameter int BURST_W    = 8,
    parameter int CYC_W      = 32,
    parameter int PC_W       = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               btn_mode,
    input  logic               btn_step,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [PC_W-1:0]    pc,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic               bp_valid,
    output logic               clk_en,
    output logic [1:0]         mode,
    output logic               busy,
    output logic               halted,
    output logic [CYC_W-1:0]   cycle_cnt
);
    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_STEP  = 2'b01,
        MODE_BURST = 2'b10
    } mode_t;

    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
    localparam logic [CYC_W-1:0]   CYC_ONE   = CYC_W'(1);

    logic               mode_press_s;
    logic               step_press_s;
    logic               bp_hit_s;

    mode_t              mode_r,   mode_nxt_s;
    logic               busy_r,   busy_nxt_s;
    logic               en_r,     en_nxt_s;
    logic               halted_r, halted_nxt_s;
    logic [BURST_W-1:0] rem_r,    rem_nxt_s;
    logic [CYC_W-1:0]   cnt_r;

    clock_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clock (clock),
        .reset (reset),
        .btn   (btn_mode),
        .press (mode_press_s)
    );

    clock_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clock (clock),
        .reset (reset),
        .btn   (btn_step),
        .press (step_press_s)
    );

`ifdef CLOCK_CTRL_BREAK_EN
    // A breakpoint only counts in a cycle where the core actually executes.
    assign bp_hit_s = en_r & bp_valid & (pc == bp_addr);
`else
    logic unused_bp_s;
    assign bp_hit_s    = 1'b0;
    assign unused_bp_s = ^{pc, bp_addr, bp_valid};
`endif

    // Next-state logic: breakpoint beats mode press, mode press beats step press.
    always_comb begin
        mode_nxt_s   = mode_r;
        busy_nxt_s   = busy_r;
        rem_nxt_s    = rem_r;
        halted_nxt_s = halted_r;
        en_nxt_s     = 1'b0;
        if (bp_hit_s) begin
            halted_nxt_s = 1'b1;
            mode_nxt_s   = MODE_STEP;
            busy_nxt_s   = 1'b0;
            rem_nxt_s    = {BURST_W{1'b0}};
        end else if (mode_press_s) begin
            // Any mode press aborts a running burst and releases a halt.
            halted_nxt_s = 1'b0;
            busy_nxt_s   = 1'b0;
            rem_nxt_s    = {BURST_W{1'b0}};
            case (mode_r)
                MODE_RUN:   mode_nxt_s = MODE_STEP;
                MODE_STEP:  mode_nxt_s = MODE_BURST;
                MODE_BURST: mode_nxt_s = MODE_RUN;
                default:    mode_nxt_s = MODE_RUN;
            endcase
            en_nxt_s = (mode_nxt_s == MODE_RUN);
        end else begin
            halted_nxt_s = step_press_s ? 1'b0 : halted_r;
            case (mode_r)
                MODE_RUN: begin
                    en_nxt_s = ~halted_nxt_s;
                end
                MODE_STEP: begin
                    en_nxt_s = step_press_s;
                end
                MODE_BURST: begin
                    // rem holds the enables still owed after the current one.
                    if (busy_r) begin
                        if (rem_r != {BURST_W{1'b0}}) begin
                            rem_nxt_s = rem_r - BURST_ONE;
                            en_nxt_s  = 1'b1;
                        end else begin
                            busy_nxt_s = 1'b0;
                        end
                    end else if (step_press_s && (burst_len != {BURST_W{1'b0}})) begin
                        busy_nxt_s = 1'b1;
                        rem_nxt_s  = burst_len - BURST_ONE;
                        en_nxt_s   = 1'b1;
                    end else begin
                        en_nxt_s = 1'b0;
                    end
                end
                default: begin
                    mode_nxt_s = MODE_RUN;
                end
            endcase
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_r   <= MODE_RUN;
            busy_r   <= 1'b0;
            rem_r    <= {BURST_W{1'b0}};
            en_r     <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            mode_r   <= mode_nxt_s;
            busy_r   <= busy_nxt_s;
            rem_r    <= rem_nxt_s;
            en_r     <= en_nxt_s;
            halted_r <= halted_nxt_s;
        end
    end

    // Retired-cycle counter, wraps naturally at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CYC_W{1'b0}};
        end else if (en_r) begin
            cnt_r <= cnt_r + CYC_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign clk_en    = en_r;
    assign mode      = mode_r;
    assign busy      = busy_r;
    assign halted    = halted_r;
    assign cycle_cnt = cnt_r;
endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Parametrised run-control unit for the MIPS board. It debounces the front-panel mode and step buttons and selects one of three execution modes: free RUN, single STEP, or fixed-length BURST. It drives a single-cycle-wide clock enable (`clk_en`) to the CPU core, so the core runs from the undivided board clock and no clock is gated. It keeps a retired-cycle counter and, when compiled in, halts on a PC breakpoint.

## Interface
Parameters:
- `DEB_CYCLES`, default 250000: consecutive cycles a synchronised button level must differ from its stable level before it is accepted; legal range ≥1.
- `BURST_W`, default 8: width of the burst length and remaining-count.
- `CYC_W`, default 32: width of the cycle counter.
- `PC_W`, default 32: width of the breakpoint compare.

Ports (name, direction, width, meaning):
- `clock` in 1: board clock; all state is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `btn_mode` in 1: raw mode button, active-high, asynchronous.
- `btn_step` in 1: raw step/trigger button, active-high, asynchronous.
- `burst_len` in BURST_W: cycles per burst; sampled on trigger.
- `pc` in PC_W: core program counter (breakpoint build only).
- `bp_addr` in PC_W: breakpoint address (breakpoint build only).
- `bp_valid` in 1: breakpoint armed (breakpoint build only).
- `clk_en` out 1: registered CPU clock enable.
- `mode` out 2: 2'b00 RUN, 2'b01 STEP, 2'b10 BURST; 2'b11 never driven.
- `busy` out 1: burst in progress.
- `halted` out 1: breakpoint hit; held until cleared.
- `cycle_cnt` out CYC_W: number of cycles with `clk_en`=1.

## Operation
- Button path (per button):
  - 2-flop synchroniser feeds a debounce counter.
  - The counter clears whenever the synchronised level equals the stable level; otherwise it increments.
  - On reaching DEB_CYCLES the stable level flips and the counter clears.
  - A stable 0→1 transition produces a registered 1-cycle press pulse. Releases produce nothing.
- Mode FSM, advanced by a mode press:
  - RUN→STEP→BURST→RUN.
  - A mode press in BURST while `busy` aborts the burst (remaining:=0, `busy`:=0) and enters RUN.
- RUN: `clk_en`=1 every cycle unless `halted`. Step presses are ignored.
- STEP: each step press gives `clk_en`=1 for exactly one cycle.
- BURST:
  - A step press while !`busy` with `burst_len`≠0 loads remaining:=`burst_len` and sets `busy`.
  - `clk_en`=1 for exactly `burst_len` consecutive cycles, then `busy` drops in the cycle after the last enable.
  - `burst_len`=0: the press is ignored. A step press while `busy` is ignored.
- `cycle_cnt` increments by 1 in every cycle where `clk_en`=1 and wraps from all-ones to 0.
- Simultaneous mode and step press pulses in the same cycle: the mode press wins and the step press is discarded.
- Reset (any time, including mid-burst): mode=RUN, `clk_en`=0, `busy`=0, `halted`=0, `cycle_cnt`=0, remaining=0, debounce counters=0, stable levels=0, synchronisers=0.

## Timing
- Press latency: the press pulse is high in cycle DEB_CYCLES+3, counted from the first `clock` edge that samples the raw button high. The raw level is taken as constant from that edge.
- `clk_en` latency:
  - STEP: `clk_en` is high in the cycle after the press pulse.
  - BURST: the first enable falls in the cycle after the press pulse.
  - RUN: after reset deasserts, `clk_en` rises on the first `clock` edge.
- Mode change latency: `mode` updates in the cycle after the press pulse. From that cycle, `clk_en` follows the new mode.
- `cycle_cnt` updates one cycle after the `clk_en` cycle it counts.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `CLOCK_CTRL_BREAK_EN`.
- When defined:
  - In any cycle with `clk_en`=1, `bp_valid`=1 and `pc`==`bp_addr`, the next cycle sets `halted`=1, forces mode=STEP and aborts any burst.
  - `halted` clears on the next mode or step press. That press also performs its normal action.
  - While `halted`, RUN gives no enables.
- When undefined:
  - `pc`, `bp_addr` and `bp_valid` stay on the port list and are ignored.
  - `halted` is tied to 0, and no compare logic is synthesised.

## Test plan
Bench uses DEB_CYCLES=4, BURST_W=8.
- Reset release in RUN: `clk_en`=1 from the first edge. After 10 cycles, `cycle_cnt`=10.
- Bounce: `btn_mode` toggling every 2 cycles for 20 cycles, then held high → exactly one mode press, and mode becomes STEP.
- STEP:
  - Three step presses → exactly 3 `clk_en` pulses, each 1 cycle wide.
  - `cycle_cnt` increases by 3.
- BURST:
  - `burst_len`=5 plus a step press → 5 consecutive enables, and `busy` is high for 5 cycles.
  - A second step press mid-burst is ignored.
  - `burst_len`=0 gives no enables.
- Abort and reset:
  - A mode press at enable 2 of a 10-cycle burst → `busy`=0 and mode=RUN.
  - Asserting `reset` mid-burst → all outputs return to their reset values, as listed under Operation.
- Breakpoint (`CLOCK_CTRL_BREAK_EN` defined):
  - RUN with `pc` incrementing by 4, `bp_addr`=0x40 and `bp_valid`=1 → `halted`=1 and mode=STEP in the cycle after `pc`=0x40.
  - A step press then gives one enable and `halted`=0.
